gmii_rx_frame: RTL and testbench
================================

Name: gmii_rx_frame

Overview:
- Downstream stage of the RGMII-to-GMII receive converter; runs in the recovered `gmii_rx_clk` domain.
- Consumes the GMII byte stream. Detects preamble/SFD, strips preamble, SFD and FCS, and emits frame bytes with start and end markers.
- Checks CRC32, frame length and (optionally) destination MAC. Reports per-frame status with the last byte.
- Feeds the MAC receive FIFO.

Parameters:
- MIN_PREAMBLE, 2: minimum 0x55 bytes required before SFD 0xD5.
- MAX_FRAME, 1518: maximum frame length in bytes, DA through FCS inclusive.
- MIN_FRAME, 64: minimum frame length in bytes, DA through FCS inclusive.
- LOCAL_MAC, 48'h00_0A_35_01_FE_C0: station address; used only when RX_MAC_FILTER_EN is defined.

Ports:
- gmii_rx_clk  input  1  receive clock; all logic on rising edge.
- rst_n  input  1  reset.
- gmii_rx_dv  input  1  GMII data valid.
- gmii_rxd  input  8  GMII data byte.
- rx_data  output  8  frame byte (DA onward, FCS stripped).
- rx_valid  output  1  rx_data valid this cycle.
- rx_sof  output  1  first byte of frame; qualified by rx_valid.
- rx_eof  output  1  last byte of frame; qualified by rx_valid.
- rx_crc_err  output  1  FCS mismatch; valid with rx_eof.
- rx_len_err  output  1  runt or oversize; valid with rx_eof.
- rx_len  output  11  payload byte count excluding FCS; valid with rx_eof.

Behaviour:
- Single clock domain: `gmii_rx_clk`. Reset is asynchronous, active-low (`rst_n`).
- Reset values:
  - All outputs 0; CRC register 0xFFFFFFFF; counters 0.
  - FSM enters DROP, so a frame already in progress at reset release is never partially delivered.
- All inputs are registered once before use.
- FSM states and transitions:
  - DROP: wait for dv=0, then go to IDLE.
  - IDLE:
    - dv=1 & rxd=0x55: go to PREAMBLE, pre_cnt=1.
    - dv=1 & any other byte: go to DROP.
  - PREAMBLE:
    - 0x55: pre_cnt++ (saturates at 7).
    - 0xD5 with pre_cnt>=MIN_PREAMBLE: go to DATA, clear CRC/len.
    - 0xD5 with pre_cnt below minimum, or any other byte: go to DROP.
    - dv=0: go to IDLE, no output.
  - DATA:
    - Each byte feeds CRC32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) and a 5-byte holding shift register; frame byte counter increments.
    - dv=0: finalize frame, go to IDLE.
- Output timing:
  - Frame byte k (k=0 is the first byte after SFD) is emitted with rx_valid=1 in the cycle following the sample slot k+5. A slot is either a byte or the first dv=0 sample.
  - Result: the 4 bytes held at frame end are the FCS and are never emitted.
  - The last payload byte is emitted with rx_eof=1 in the cycle after dv falls.
  - rx_sof=1 with k=0.
  - Gaps in dv are not supported; a dv drop always ends the frame.
- End-of-frame status:
  - CRC residue over all post-SFD bytes including FCS must equal 0xDEBB20E3 (pre-inversion) for rx_crc_err=0.
  - rx_len = total bytes - 4.
  - rx_len_err=1 if total < MIN_FRAME.
- Short frames: a frame of <=4 bytes after SFD emits nothing, including no rx_eof.
- Oversize:
  - When the byte counter reaches MAX_FRAME and dv is still 1: flush the held byte k=MAX_FRAME-5 with rx_eof=1, rx_len_err=1, rx_crc_err=1, rx_len=MAX_FRAME-4.
  - Go to DROP; no further output until dv=0.
- Back-to-back frames:
  - The finalize cycle and the next frame's preamble may overlap.
  - The holding register must be drained before the new SFD, which always holds given >=1 preamble byte.
  - rx_valid is never asserted on two consecutive frames in the same cycle.
- rx_crc_err, rx_len_err and rx_len are 0 whenever rx_eof=0.

Optional Feature:
- RX_MAC_FILTER_EN defined:
  - At sample slot 5 (DA complete, byte 0 not yet emitted), compare DA to LOCAL_MAC, FF:FF:FF:FF:FF:FF, and multicast (DA[40]=1).
  - On no match: emit nothing for the whole frame and go to DROP.
  - Frames too short to reach slot 5 are also discarded.
- Not defined: all frames are passed; LOCAL_MAC is ignored.

Test Plan:
- 7x0x55, 0xD5, 60 data bytes + valid FCS, dv low -> 60 rx_valid bytes matching input; sof on byte 0; eof on byte 59 one cycle after dv falls; rx_len=60, errors 0.
- Same frame with FCS last byte XOR 0x01 -> identical data; rx_crc_err=1 at eof.
- 7x0x55, 0xD5, 40 bytes total with valid FCS -> 36 bytes out; rx_len=36, rx_len_err=1.
- 1600-byte frame -> 1514 bytes out; eof on byte 1513 with rx_len_err=1, rx_crc_err=1, rx_len=1514; nothing further until dv drops; next valid frame is received correctly.
- rst_n pulsed low mid-frame at byte 30 -> outputs 0 immediately; no output for the rest of that frame; next frame after an IFG of 12 cycles is received correctly.
- RX_MAC_FILTER_EN with DA=00:11:22:33:44:55 -> no rx_valid; with DA=LOCAL_MAC or broadcast -> full frame out.

Source files
------------

// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame: GMII receive framer; strips preamble/SFD/FCS, checks CRC32 and length.
// Define RX_MAC_FILTER_EN to discard frames whose DA is not local, broadcast or multicast.
module gmii_rx_frame #(
  parameter int unsigned MIN_PREAMBLE = 2,
  parameter int unsigned MAX_FRAME    = 1518,
  parameter int unsigned MIN_FRAME    = 64,
  parameter logic [47:0] LOCAL_MAC    = 48'h00_0A_35_01_FE_C0
) (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_crc_err,
  output logic        rx_len_err,
  output logic [10:0] rx_len
);

  localparam int unsigned CNT_W      = $clog2(MAX_FRAME + 1);
  localparam int unsigned HOLD_BYTES = 5;
  localparam int unsigned HOLD_W     = 8 * HOLD_BYTES;
  localparam logic [7:0]  PRE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE   = 8'hD5;
  localparam logic [31:0] CRC_POLY_R = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

`ifdef RX_MAC_FILTER_EN
  localparam logic PASS_INIT = 1'b0;

  function automatic logic mac_match(input logic [47:0] da);
    return (da == LOCAL_MAC) || (da == '1) || da[40];
  endfunction
`else
  localparam logic PASS_INIT = 1'b1;
  logic [47:0] local_mac_unused;
  assign local_mac_unused = LOCAL_MAC;
`endif

  typedef enum logic [1:0] {S_DROP, S_IDLE, S_PREAMBLE, S_DATA} state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
    return r;
  endfunction

  state_t              state, state_d;
  logic                dv_q;
  logic [7:0]          rxd_q;
  logic [2:0]          pre_cnt, pre_cnt_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [31:0]         crc, crc_d;
  logic [HOLD_W-1:0]   hold, hold_d;
  logic                pass, pass_d;
  logic [7:0]          data_d;
  logic                valid_d, sof_d, eof_d, crc_err_d, len_err_d;
  logic [10:0]         len_d;

  // Registers; dv_q resets busy so DROP only exits on a genuinely sampled idle.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_DROP;
      dv_q       <= 1'b1;
      rxd_q      <= '0;
      pre_cnt    <= '0;
      cnt        <= '0;
      crc        <= '1;
      hold       <= '0;
      pass       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_len_err <= 1'b0;
      rx_len     <= '0;
    end else begin
      state      <= state_d;
      dv_q       <= gmii_rx_dv;
      rxd_q      <= gmii_rxd;
      pre_cnt    <= pre_cnt_d;
      cnt        <= cnt_d;
      crc        <= crc_d;
      hold       <= hold_d;
      pass       <= pass_d;
      rx_data    <= data_d;
      rx_valid   <= valid_d;
      rx_sof     <= sof_d;
      rx_eof     <= eof_d;
      rx_crc_err <= crc_err_d;
      rx_len_err <= len_err_d;
      rx_len     <= len_d;
    end
  end

  // Next state, datapath and output decode.
  always_comb begin
    state_d   = state;
    pre_cnt_d = pre_cnt;
    cnt_d     = cnt;
    crc_d     = crc;
    hold_d    = hold;
    pass_d    = pass;
    data_d    = '0;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    crc_err_d = 1'b0;
    len_err_d = 1'b0;
    len_d     = '0;
    case (state)
      S_DROP: if (!dv_q) state_d = S_IDLE;
      S_IDLE: begin
        if (dv_q) begin
          if (rxd_q == PRE_BYTE) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_PREAMBLE: begin
        if (!dv_q) begin
          state_d = S_IDLE;
        end else if (rxd_q == PRE_BYTE) begin
          if (pre_cnt != 3'd7) pre_cnt_d = pre_cnt + 3'd1;
        end else if (rxd_q == SFD_BYTE && pre_cnt >= 3'(MIN_PREAMBLE)) begin
          state_d = S_DATA;
          cnt_d   = '0;
          crc_d   = '1;
          hold_d  = '0;
          pass_d  = PASS_INIT;
        end else begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (!dv_q) begin
          // Frame end: the four held bytes behind the emitted one are the FCS.
          state_d = S_IDLE;
          if (pass && cnt >= CNT_W'(HOLD_BYTES)) begin
            valid_d   = 1'b1;
            data_d    = hold[HOLD_W-1 -: 8];
            sof_d     = (cnt == CNT_W'(HOLD_BYTES));
            eof_d     = 1'b1;
            crc_err_d = (crc != CRC_RESIDUE);
            len_err_d = (cnt < CNT_W'(MIN_FRAME));
            len_d     = 11'(cnt - CNT_W'(4));
          end
        end else if (cnt == CNT_W'(MAX_FRAME)) begin
          state_d = S_DROP;
          if (pass) begin
            valid_d   = 1'b1;
            data_d    = hold[HOLD_W-1 -: 8];
            eof_d     = 1'b1;
            crc_err_d = 1'b1;
            len_err_d = 1'b1;
            len_d     = 11'(MAX_FRAME - 4);
          end
        end else begin
          cnt_d  = cnt + CNT_W'(1);
          crc_d  = crc32_byte(crc, rxd_q);
          hold_d = {hold[HOLD_W-9:0], rxd_q};
`ifdef RX_MAC_FILTER_EN
          if (cnt == CNT_W'(HOLD_BYTES)) begin
            pass_d = mac_match({hold, rxd_q});
            if (!pass_d) state_d = S_DROP;
          end
`endif
          if (pass_d && cnt >= CNT_W'(HOLD_BYTES)) begin
            valid_d = 1'b1;
            data_d  = hold[HOLD_W-1 -: 8];
            sof_d   = (cnt == CNT_W'(HOLD_BYTES));
          end
        end
      end
      default: state_d = S_DROP;
    endcase
  end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb_gmii_rx_frame: randomized frame stimulus with a queue scoreboard for gmii_rx_frame.
// Honours RX_MAC_FILTER_EN in its reference model when the design is built with it.
module tb_gmii_rx_frame;

  localparam int unsigned MIN_PREAMBLE = 2;
  localparam int unsigned MAX_FRAME    = 1518;
  localparam int unsigned MIN_FRAME    = 64;
  localparam logic [47:0] LOCAL_MAC    = 48'h00_0A_35_01_FE_C0;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic        crc_err;
    logic        len_err;
    logic [10:0] len;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_crc_err, rx_len_err;
  logic [10:0] rx_len;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gmii_rx_frame #(
    .MIN_PREAMBLE(MIN_PREAMBLE), .MAX_FRAME(MAX_FRAME),
    .MIN_FRAME(MIN_FRAME), .LOCAL_MAC(LOCAL_MAC)
  ) dut (
    .gmii_rx_clk(clk), .rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_crc_err(rx_crc_err), .rx_len_err(rx_len_err), .rx_len(rx_len)
  );

  // Monitor: every valid beat must match the head of the expectation queue.
  beat_t got, exp_b;
  always @(negedge clk) begin
    got = {rx_data, rx_sof, rx_eof, rx_crc_err, rx_len_err, rx_len};
    checks++;
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got data=%02h sof=%0b eof=%0b crc=%0b lenerr=%0b len=%0d",
                 got.data, got.sof, got.eof, got.crc_err, got.len_err, got.len);
      end else begin
        exp_b = exp_q.pop_front();
        if (got !== exp_b) begin
          errors++;
          $display("FAIL beat got data=%02h sof=%0b eof=%0b crc=%0b lenerr=%0b len=%0d exp data=%02h sof=%0b eof=%0b crc=%0b lenerr=%0b len=%0d",
                   got.data, got.sof, got.eof, got.crc_err, got.len_err, got.len,
                   exp_b.data, exp_b.sof, exp_b.eof, exp_b.crc_err, exp_b.len_err, exp_b.len);
        end
      end
    end else if ({rx_sof, rx_eof, rx_crc_err, rx_len_err, rx_len} !== 15'd0) begin
      errors++;
      $display("FAIL idle_markers got sof=%0b eof=%0b crc=%0b lenerr=%0b len=%0d exp all 0",
               rx_sof, rx_eof, rx_crc_err, rx_len_err, rx_len);
    end
  end

  function automatic logic [31:0] fcs_of(input bytes_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Frame of len payload bytes (DA first) plus FCS, optionally with the last FCS byte ^ 0x01.
  function automatic bytes_t build(input int len, input logic [47:0] da, input bit bad);
    bytes_t b;
    logic [31:0] f;
    for (int i = 0; i < len; i++)
      b.push_back(i < 6 ? da[47 - 8*i -: 8] : 8'($urandom));
    f = fcs_of(b);
    b.push_back(f[7:0]);
    b.push_back(f[15:8]);
    b.push_back(f[23:16]);
    b.push_back(bad ? (f[31:24] ^ 8'h01) : f[31:24]);
    return b;
  endfunction

  function automatic bytes_t raw(input int n);
    bytes_t b;
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  // Reference model: which beats a frame must produce, from the frame rules alone.
  task automatic model(input int pre, input bytes_t fr, input bit bad);
    int n;
    int last;
    beat_t e;
    n = fr.size();
    if (pre < int'(MIN_PREAMBLE)) return;
`ifdef RX_MAC_FILTER_EN
    if (n < 6) return;
    if (!({fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]} == LOCAL_MAC ||
          {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]} == 48'hFFFF_FFFF_FFFF ||
          fr[0][0])) return;
`endif
    if (n > int'(MAX_FRAME)) begin
      last = MAX_FRAME - 5;
      for (int k = 0; k <= last; k++) begin
        e = '0;
        e.data = fr[k];
        e.sof = (k == 0);
        if (k == last) begin
          e.eof = 1'b1; e.crc_err = 1'b1; e.len_err = 1'b1; e.len = 11'(MAX_FRAME - 4);
        end
        exp_q.push_back(e);
      end
    end else if (n >= 5) begin
      last = n - 5;
      for (int k = 0; k <= last; k++) begin
        e = '0;
        e.data = fr[k];
        e.sof = (k == 0);
        if (k == last) begin
          e.eof = 1'b1; e.crc_err = bad; e.len_err = (n < int'(MIN_FRAME)); e.len = 11'(n - 4);
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    dv = v;
    rxd = d;
  endtask

  task automatic send(input int pre, input bytes_t fr, input bit bad, input int ifg);
    model(pre, fr, bad);
    for (int i = 0; i < pre; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    foreach (fr[i]) drive(1'b1, fr[i]);
    for (int i = 0; i < ifg; i++) drive(1'b0, 8'h00);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({rx_data, rx_valid, rx_sof, rx_eof, rx_crc_err, rx_len_err, rx_len} !== 24'd0) begin
      errors++;
      $display("FAIL %s got data=%02h valid=%0b sof=%0b eof=%0b crc=%0b lenerr=%0b len=%0d exp all 0",
               name, rx_data, rx_valid, rx_sof, rx_eof, rx_crc_err, rx_len_err, rx_len);
    end
  endtask

  function automatic logic [47:0] pick_da(input int sel);
    logic [47:0] d;
    d = {16'($urandom), 32'($urandom)};
    case (sel)
      0: d = LOCAL_MAC;
      1: d = 48'hFFFF_FFFF_FFFF;
      2: d[40] = 1'b1;
      default: d[40] = 1'b0;
    endcase
    return d;
  endfunction

  bytes_t fr;
  beat_t  e;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_state");
    rst_n = 1'b1;
    repeat (4) drive(1'b0, 8'h00);

    // Nominal 64-byte frame, then the same payload with a corrupted FCS.
    fr = build(60, LOCAL_MAC, 1'b0);
    send(7, fr, 1'b0, 12);
    fr[63] = fr[63] ^ 8'h01;
    send(7, fr, 1'b1, 12);
    // Runt (40 total) and the 63/64-byte length boundary.
    send(7, build(36, LOCAL_MAC, 1'b0), 1'b0, 12);
    send(7, build(59, LOCAL_MAC, 1'b0), 1'b0, 12);
    send(7, build(60, 48'hFFFF_FFFF_FFFF, 1'b0), 1'b0, 1);
    // Short frames: 0..4 bytes after SFD emit nothing; 5 bytes is one byte with sof+eof.
    for (int n = 0; n <= 4; n++) send(7, raw(n), 1'b0, 3);
    send(7, build(1, LOCAL_MAC, 1'b0), 1'b0, 3);
    // Preamble too short, and bad byte before SFD.
    send(1, build(60, LOCAL_MAC, 1'b0), 1'b0, 4);
    send(0, build(60, LOCAL_MAC, 1'b0), 1'b0, 4);
    // Maximum legal frame, then oversize followed by a good frame.
    send(7, build(MAX_FRAME - 4, LOCAL_MAC, 1'b0), 1'b0, 12);
    send(7, raw(1600), 1'b0, 12);
    send(7, build(60, LOCAL_MAC, 1'b0), 1'b0, 12);
    // Destination filter candidates (all pass when the filter is not built in).
    send(7, build(60, 48'h00_11_22_33_44_55, 1'b0), 1'b0, 12);
    send(7, build(60, 48'h01_00_5E_00_00_01, 1'b0), 1'b0, 12);

    // Reset pulse at byte 30: bytes 0..23 were already delivered, nothing else from that frame.
    fr = build(60, LOCAL_MAC, 1'b0);
    for (int k = 0; k <= 23; k++) begin
      e = '0;
      e.data = fr[k];
      e.sof = (k == 0);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    foreach (fr[i]) begin
      drive(1'b1, fr[i]);
      if (i == 30) begin
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("reset_async_clear");
      end
      if (i == 33) rst_n = 1'b1;
    end
    repeat (12) drive(1'b0, 8'h00);
    send(7, build(60, LOCAL_MAC, 1'b0), 1'b0, 12);

    // Randomized traffic, including back-to-back frames with a single idle cycle.
    for (int t = 0; t < 40; t++) begin
      int pre, len, sel, ifg;
      bit bad;
      pre = int'($urandom_range(0, 8));
      len = int'($urandom_range(0, 120));
      sel = int'($urandom_range(0, 3));
      ifg = int'($urandom_range(1, 12));
      bad = ($urandom_range(0, 3) == 0);
      send(pre, build(len, pick_da(sel), bad), bad, ifg);
    end

    repeat (40) drive(1'b0, 8'h00);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending beats exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
